// File: rtl/isa_shared_pkg.sv
// Shared RV32I load/store definitions.
//   lsu_state_e        : load/store sequencer states
//   mem_access_type_e  : access size decoded from funct3[1:0]
//   sx_ops_e           : load-data extension select
//   i_/s_function3_e   : load and store funct3 encodings
//   BE_*               : byte-enable patterns before lane shift
package isa_shared;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_REQ,
      LSU_WAIT,
      LSU_RESP
   } lsu_state_e;

   typedef enum logic [1:0] {
      MEM_BYTE,
      MEM_HALF,
      MEM_WORD
   } mem_access_type_e;

   typedef enum logic [2:0] {
      SX_0700,
      SXU_0700,
      SX_1500,
      SXU_1500,
      SX_3100
   } sx_ops_e;

   typedef enum logic [2:0] {
      I_LB  = 3'b000,
      I_LH  = 3'b001,
      I_LW  = 3'b010,
      I_LBU = 3'b100,
      I_LHU = 3'b101
   } i_function3_e;

   typedef enum logic [2:0] {
      S_SB = 3'b000,
      S_SH = 3'b001,
      S_SW = 3'b010
   } s_function3_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   function automatic mem_access_type_e f3_size(input logic [1:0] f3_lo);
      case (f3_lo)
         2'b00:   return MEM_BYTE;
         2'b01:   return MEM_HALF;
         default: return MEM_WORD;
      endcase
   endfunction

   function automatic sx_ops_e f3_sx(input logic [2:0] f3);
      case (f3)
         3'b000:  return SX_0700;
         3'b100:  return SXU_0700;
         3'b001:  return SX_1500;
         3'b101:  return SXU_1500;
         default: return SX_3100;
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load-data alignment and extension (combinational).
//   rdata   : raw 32-bit word from memory
//   addr_lo : byte offset of the access within the word
//   sx      : extension select
//   data    : selected lane, sign/zero-extended to 32 bits
module lsu_load_align
   import isa_shared::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  sx_ops_e     sx,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      case (sx)
         SX_0700:  data = {{24{shifted[7]}}, shifted[7:0]};
         SXU_0700: data = {24'h0, shifted[7:0]};
         SX_1500:  data = {{16{shifted[15]}}, shifted[15:0]};
         SXU_1500: data = {16'h0, shifted[15:0]};
         default:  data = shifted;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the data-memory port.
// Accepts one request in IDLE, faults illegal/misaligned ops without touching
// memory, otherwise runs req/gnt then waits for rvalid and returns the
// extended load data (or 0 for stores) as a one-cycle rsp_valid pulse.
//   clk, rst                         : clock, synchronous active-high reset
//   req_*                            : request from execute (req_ready in IDLE)
//   rsp_valid/rsp_rdata/rsp_fault    : completion to writeback
//   busy                             : state != IDLE
//   mem_*                            : data-memory port
//
// state    | meaning
// LSU_IDLE | ready for a new request
// LSU_REQ  | mem_req asserted, waiting for gnt (bounded by TIMEOUT_CYCLES)
// LSU_WAIT | granted, waiting for rvalid (unbounded)
// LSU_RESP | rsp_valid pulse, back to IDLE next
module lsu_ctrl
   import isa_shared::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_fault,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

   lsu_state_e  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        is_store_q, is_store_d;
   logic [1:0]  addr_lo_q, addr_lo_d;
   sx_ops_e     sx_q, sx_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        rsp_fault_q, rsp_fault_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   mem_access_type_e acc_size;
   logic             f3_legal;
   logic             misaligned;
   logic [3:0]       be_new;
   logic [31:0]      wdata_new;
   logic [31:0]      load_ext;

   lsu_load_align u_align (
      .rdata   (mem_rdata),
      .addr_lo (addr_lo_q),
      .sx      (sx_q),
      .data    (load_ext)
   );

   // Decode of the request presented in IDLE.
   always_comb begin
      acc_size = f3_size(req_funct3[1:0]);
      if (req_is_store) begin
         f3_legal = (req_funct3 == S_SB) || (req_funct3 == S_SH) || (req_funct3 == S_SW);
      end else begin
         f3_legal = (req_funct3 == I_LB) || (req_funct3 == I_LH) || (req_funct3 == I_LW) ||
                    (req_funct3 == I_LBU) || (req_funct3 == I_LHU);
      end
      misaligned = ((acc_size == MEM_HALF) && req_addr[0]) ||
                   ((acc_size == MEM_WORD) && (req_addr[1:0] != 2'b00));
      case (acc_size)
         MEM_BYTE: begin
            be_new    = BE_BYTE << req_addr[1:0];
            wdata_new = {4{req_wdata[7:0]}};
         end
         MEM_HALF: begin
            be_new    = BE_HALF << req_addr[1:0];
            wdata_new = {2{req_wdata[15:0]}};
         end
         default: begin
            be_new    = BE_WORD;
            wdata_new = req_wdata;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      is_store_d  = is_store_q;
      addr_lo_d   = addr_lo_q;
      sx_d        = sx_q;
      rsp_valid_d = 1'b0;
      rsp_fault_d = 1'b0;
      rsp_rdata_d = 32'h0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      case (state_q)
         LSU_IDLE: begin
            if (req_valid) begin
               if (!f3_legal || misaligned) begin
                  state_d     = LSU_RESP;
                  rsp_valid_d = 1'b1;
                  rsp_fault_d = 1'b1;
               end else begin
                  state_d     = LSU_REQ;
                  cnt_d       = 16'h0;
                  is_store_d  = req_is_store;
                  addr_lo_d   = req_addr[1:0];
                  sx_d        = f3_sx(req_funct3);
                  mem_req_d   = 1'b1;
                  mem_we_d    = req_is_store;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = be_new;
                  mem_wdata_d = wdata_new;
               end
            end
         end
         LSU_REQ: begin
            // A grant on the last allowed cycle still wins over the timeout.
            if (mem_gnt) begin
               state_d   = LSU_WAIT;
               cnt_d     = 16'h0;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = LSU_RESP;
               cnt_d       = 16'h0;
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_fault_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         LSU_WAIT: begin
            if (mem_rvalid) begin
               state_d     = LSU_RESP;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = is_store_q ? 32'h0 : load_ext;
            end
         end
         default: begin
            state_d = LSU_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= LSU_IDLE;
         cnt_q       <= 16'h0;
         is_store_q  <= 1'b0;
         addr_lo_q   <= 2'b00;
         sx_q        <= SX_3100;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_be_q    <= 4'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         is_store_q  <= is_store_d;
         addr_lo_q   <= addr_lo_d;
         sx_q        <= sx_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_rdata_q <= rsp_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign req_ready = (state_q == LSU_IDLE);
   assign busy      = (state_q != LSU_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_fault = rsp_fault_q;
   assign rsp_rdata = rsp_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios followed by random
// load/store traffic with random grant and rvalid delays, compared against a
// byte-level reference model. Inputs change and outputs are sampled on the
// falling edge.
module tb_lsu_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_is_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        busy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] last_rdata;
   logic [3:0]  last_be;
   logic [31:0] last_wdata;
   logic        last_fault;
   logic        last_we;
   int          req_cycles;

   lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_fault    (rsp_fault),
      .busy         (busy),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_be       (mem_be),
      .mem_wdata    (mem_wdata),
      .mem_gnt      (mem_gnt),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int nbytes(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit exp_fault(input bit st, input logic [2:0] f3, input logic [31:0] a);
      bit legal;
      if (st) legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      else    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      if (!legal) return 1'b1;
      return (a % nbytes(f3)) != 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] be = 4'h0;
      int off = int'(a[1:0]);
      for (int i = 0; i < nbytes(f3); i++)
         if (off + i < 4) be[off + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] w);
      logic [31:0] r;
      int n = nbytes(f3);
      for (int j = 0; j < 4; j++) r[8*j +: 8] = w[8*(j % n) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      longint v = 0;
      int off = int'(a[1:0]);
      int n = nbytes(f3);
      for (int i = 0; i < n; i++) v = v | (longint'(rd[8*(off + i) +: 8]) << (8*i));
      if (!f3[2] && n < 4 && (((v >> (8*n - 1)) & 1) == 1)) v = v - (longint'(1) << (8*n));
      return 32'(v);
   endfunction

   // ---------------- driver ----------------
   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, req_ready, 1);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_rspv"},  rsp_valid, 0);
      chk({tag, "_rspf"},  rsp_fault, 0);
      chk({tag, "_rspd"},  rsp_rdata, 0);
      chk({tag, "_mreq"},  mem_req, 0);
      chk({tag, "_mwe"},   mem_we, 0);
      chk({tag, "_maddr"}, mem_addr, 0);
      chk({tag, "_mbe"},   mem_be, 0);
      chk({tag, "_mwd"},   mem_wdata, 0);
   endtask

   // Called at a falling edge with the DUT idle; returns at a falling edge
   // with the DUT idle again.
   task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, input logic [31:0] rd,
                         input int gdly, input int rvdly);
      bit f = exp_fault(st, f3, a);
      chk("idle_ready", req_ready, 1);
      req_valid    = 1'b1;
      req_is_store = st;
      req_funct3   = f3;
      req_addr     = a;
      req_wdata    = w;
      @(negedge clk);
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      req_funct3 = 3'($urandom);
      req_cycles = 0;
      if (f) begin
         chk("flt_mreq",  mem_req, 0);
         chk("flt_valid", rsp_valid, 1);
         chk("flt_fault", rsp_fault, 1);
         chk("flt_rdata", rsp_rdata, 0);
         last_fault = rsp_fault;
         last_rdata = rsp_rdata;
      end else begin
         for (int n = 0; n < TO; n++) begin
            chk("req_mreq",  mem_req, 1);
            chk("req_busy",  busy, 1);
            chk("req_we",    mem_we, 32'(st));
            chk("req_addr",  mem_addr, a & 32'hFFFF_FFFC);
            chk("req_be",    mem_be, exp_be(f3, a));
            if (st) chk("req_wdata", mem_wdata, exp_wdata(f3, w));
            last_be    = mem_be;
            last_wdata = mem_wdata;
            last_we    = mem_we;
            req_cycles++;
            if (n == gdly) begin
               mem_gnt = 1'b1;
               @(negedge clk);
               mem_gnt = 1'b0;
               break;
            end
            @(negedge clk);
         end
         if (gdly >= TO) begin
            chk("to_cycles", 32'(req_cycles), TO);
            chk("to_mreq",   mem_req, 0);
            chk("to_valid",  rsp_valid, 1);
            chk("to_fault",  rsp_fault, 1);
            chk("to_rdata",  rsp_rdata, 0);
            last_fault = rsp_fault;
            last_rdata = rsp_rdata;
         end else begin
            chk("wait_mreq", mem_req, 0);
            for (int k = 1; k < rvdly; k++) begin
               chk("wait_valid", rsp_valid, 0);
               @(negedge clk);
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            chk("rsp_valid", rsp_valid, 1);
            chk("rsp_fault", rsp_fault, 0);
            chk("rsp_rdata", rsp_rdata, st ? 32'h0 : exp_load(f3, a, rd));
            last_fault = rsp_fault;
            last_rdata = rsp_rdata;
         end
      end
      @(negedge clk);
      chk("post_valid", rsp_valid, 0);
      chk("post_ready", req_ready, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      req_valid    = 1'b0;
      req_is_store = 1'b0;
      req_funct3   = 3'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      mem_gnt      = 1'b0;
      mem_rvalid   = 1'b1;   // stale rvalid around reset must be ignored
      mem_rdata    = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_reset_vals("rst");
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("rst_stale_valid", rsp_valid, 0);
      chk("rst_stale_busy",  busy, 0);

      // LB at 0x1003
      do_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 1);
      chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
      chk("lb_be",    last_be, 4'b1000);
      chk("lb_fault", last_fault, 0);
      // LHU / LH at 0x2002
      do_txn(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 1);
      chk("lhu_rdata", last_rdata, 32'h0000_BEEF);
      do_txn(1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 1, 2);
      chk("lh_rdata", last_rdata, 32'hFFFF_BEEF);
      // SB / SH
      do_txn(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A5, 32'h0, 0, 1);
      chk("sb_be",    last_be, 4'b0010);
      chk("sb_wdata", last_wdata, 32'hA5A5_A5A5);
      chk("sb_we",    last_we, 1);
      chk("sb_rdata", last_rdata, 0);
      do_txn(1'b1, 3'b001, 32'h0000_3002, 32'h0000_1234, 32'h0, 0, 1);
      chk("sh_be",    last_be, 4'b1100);
      chk("sh_wdata", last_wdata, 32'h1234_1234);
      // faults: misaligned LW, illegal load funct3, illegal store funct3
      do_txn(1'b0, 3'b010, 32'h0000_4002, 32'h0, 32'h0, 0, 1);
      chk("lw_mis_fault", last_fault, 1);
      do_txn(1'b0, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 0, 1);
      chk("ld011_fault", last_fault, 1);
      do_txn(1'b1, 3'b100, 32'h0000_4000, 32'h0, 32'h0, 0, 1);
      chk("st100_fault", last_fault, 1);

      // grant timeout, then a late rvalid while idle
      do_txn(1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h0, TO + 10, 1);
      chk("to_req_cycles", 32'(req_cycles), TO);
      mem_rvalid = 1'b1;
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("late_rv_valid", rsp_valid, 0);
      chk("late_rv_busy",  busy, 0);
      do_txn(1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h1357_9BDF, 0, 1);
      chk("after_to_rdata", last_rdata, 32'h1357_9BDF);

      // grant on the very last allowed cycle
      do_txn(1'b0, 3'b100, 32'h0000_7001, 32'h0, 32'h0000_F000, TO - 1, 1);
      chk("late_gnt_rdata", last_rdata, 32'h0000_00F0);

      // reset while in WAIT, rvalid arrives the next cycle
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_5000;
      @(negedge clk);
      req_valid = 1'b0;
      chk("mid_mreq", mem_req, 1);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      chk("mid_wait_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hCAFE_F00D;
      chk_reset_vals("midrst");
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("midrst_no_rsp", rsp_valid, 0);
      do_txn(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'h2468_ACE0, 0, 1);
      chk("midrst_lw", last_rdata, 32'h2468_ACE0);

      // random traffic
      for (int t = 0; t < 60; t++) begin
         bit          st = 1'($urandom_range(0, 1));
         logic [2:0]  f3;
         logic [31:0] a  = $urandom;
         int          gd = $urandom_range(0, TO + 1);
         int          rv = $urandom_range(1, 3);
         if ($urandom_range(0, 5) == 0) f3 = 3'($urandom);
         else if (st) f3 = 3'($urandom_range(0, 2));
         else begin
            case ($urandom_range(0, 4))
               0: f3 = 3'd0;
               1: f3 = 3'd1;
               2: f3 = 3'd2;
               3: f3 = 3'd4;
               default: f3 = 3'd5;
            endcase
         end
         if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
         do_txn(st, f3, a, $urandom, $urandom, gd, rv);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
